bp_mem_port_arbiter: RTL and testbench
======================================

BP_MEM_PORT_ARBITER -- requirements
Module: bp_mem_port_arbiter

Interface
REQ-001 Parameter msg_width_p, default 512: width of one packed command/response memory message.
REQ-002 Parameter track_els_p, default 4: depth of the outstanding-request tracking FIFO; power of two, >= 2.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd0_i / cmd1_i  input  msg_width_p each  command from requester 0 (core) / requester 1 (host loader).
REQ-006 cmd0_v_i / cmd1_v_i  input  1 each  command valid.
REQ-007 cmd0_ready_o / cmd1_ready_o  output  1 each  command accepted when v & ready.
REQ-008 resp0_o / resp1_o  output  msg_width_p each  response to each requester.
REQ-009 resp0_v_o / resp1_v_o  output  1 each  response valid.
REQ-010 resp0_yumi_i / resp1_yumi_i  input  1 each  response consumed; legal only while matching v_o = 1.
REQ-011 mem_cmd_o  output  msg_width_p  command to the shared memory.
REQ-012 mem_cmd_v_o  output  1  command valid.
REQ-013 mem_cmd_ready_i  input  1  memory can accept a command.
REQ-014 mem_resp_i  input  msg_width_p  in-order response from memory.
REQ-015 mem_resp_v_i  input  1  response valid.
REQ-016 mem_resp_yumi_o  output  1  response consumed.
REQ-017 outstanding_o  output  log2(track_els_p)+1  number of issued, un-returned commands.
REQ-018 error_o  output  1  sticky flag: response with no outstanding command.

Function
REQ-019 Command path SHALL be zero-latency combinational: mem_cmd_o = cmd of granted requester; mem_cmd_v_o = granted requester's v & can_issue.
REQ-020 can_issue SHALL equal mem_cmd_ready_i & (outstanding_o < track_els_p); a full tracker blocks issue even if a pop occurs the same cycle.
REQ-021 Grant: single valid requester wins; both valid -> requester != last_grant wins (round-robin).
REQ-022 cmdX_ready_o SHALL equal can_issue & (X granted, or other requester not valid); never asserted for both requesters with both valid.
REQ-023 last_grant SHALL update to the winner only on an accepted transfer (v & ready); unchanged otherwise.
REQ-024 Each accepted command SHALL push the winner ID (1 bit) into the tracking FIFO.
REQ-025 Response routing: when FIFO non-empty, head ID X selects respX_o = mem_resp_i, respX_v_o = mem_resp_v_i; other resp_v_o = 0.
REQ-026 mem_resp_yumi_o SHALL equal respX_yumi_i of the head requester; a yumi pops the FIFO head the same edge.
REQ-027 Push and pop in the same cycle (non-full) SHALL leave outstanding_o unchanged; read/write pointers wrap modulo track_els_p.
REQ-028 mem_resp_v_i with FIFO empty SHALL set error_o next cycle, hold both resp_v_o = 0, and assert mem_resp_yumi_o to drop the response.
REQ-029 error_o SHALL remain 1 until reset.
REQ-030 resp_o data SHALL be driven to mem_resp_i for both requesters; only v_o is gated.

Reset
REQ-031 reset_n_i = 0 SHALL asynchronously clear FIFO pointers, outstanding_o = 0, last_grant = 1 (requester 0 wins first tie), error_o = 0.
REQ-032 During reset all ready_o, v_o and yumi_o outputs SHALL be 0; reset mid-transaction discards tracked IDs with no responses delivered.

Verification
REQ-033 Both cmd_v held 1, mem_cmd_ready_i = 1, track_els_p = 4 -> grants 0,1,0,1, then ready_o = 0 until a response pops; outstanding_o reaches 4.
REQ-034 Issue cmd0, cmd1, cmd0; memory returns 3 responses in order -> resp0_v_o, resp1_v_o, resp0_v_o in sequence, outstanding_o 3->0.
REQ-035 Requester holds resp_yumi_i = 0 for 5 cycles -> mem_resp_yumi_o = 0, FIFO head unchanged, response delivered on the 6th cycle.
REQ-036 mem_resp_v_i = 1 with outstanding_o = 0 -> error_o = 1 next cycle, mem_resp_yumi_o = 1, no resp_v_o; error_o stays 1.
REQ-037 Full tracker plus same-cycle response pop -> no command issued that cycle; issue resumes next cycle with outstanding_o = 3.
REQ-038 Assert reset_n_i = 0 asynchronously with 2 outstanding -> outstanding_o = 0 immediately; after release requester 0 wins first tie.

Source files
------------

// File: rtl/bp_mem_port_arbiter.sv
// bp_mem_port_arbiter: round-robin two-requester memory port with in-order response routing via an ID tracking FIFO.
module bp_mem_port_arbiter #(
  parameter int msg_width_p = 512,
  parameter int track_els_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [msg_width_p-1:0]             cmd0_i,
  input  logic                               cmd0_v_i,
  output logic                               cmd0_ready_o,
  input  logic [msg_width_p-1:0]             cmd1_i,
  input  logic                               cmd1_v_i,
  output logic                               cmd1_ready_o,
  output logic [msg_width_p-1:0]             resp0_o,
  output logic                               resp0_v_o,
  input  logic                               resp0_yumi_i,
  output logic [msg_width_p-1:0]             resp1_o,
  output logic                               resp1_v_o,
  input  logic                               resp1_yumi_i,
  output logic [msg_width_p-1:0]             mem_cmd_o,
  output logic                               mem_cmd_v_o,
  input  logic                               mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]             mem_resp_i,
  input  logic                               mem_resp_v_i,
  output logic                               mem_resp_yumi_o,
  output logic [$clog2(track_els_p):0]       outstanding_o,
  output logic                               error_o
);
  localparam int pw = $clog2(track_els_p);
  localparam int cw = pw + 1;
  localparam logic [cw-1:0] full_c = cw'(track_els_p);
  logic [track_els_p-1:0] ids;
  logic [pw-1:0] rptr, wptr;
  logic [cw-1:0] cnt;
  logic last_grant, err, can_issue, g1, push, pop, empty, head;
  always_comb begin
    can_issue = reset_n_i & mem_cmd_ready_i & (cnt != full_c);
    g1 = cmd1_v_i & (~cmd0_v_i | ~last_grant);
    push = can_issue & (g1 ? cmd1_v_i : cmd0_v_i);
    empty = cnt == '0;
    head = ids[rptr];
    mem_resp_yumi_o = reset_n_i & (empty ? mem_resp_v_i : (head ? resp1_yumi_i : resp0_yumi_i));
    pop = ~empty & mem_resp_yumi_o;
  end
  assign mem_cmd_o = g1 ? cmd1_i : cmd0_i;
  assign mem_cmd_v_o = push;
  assign cmd0_ready_o = can_issue & ~g1;
  assign cmd1_ready_o = can_issue & (g1 | ~cmd0_v_i);
  assign resp0_o = mem_resp_i;
  assign resp1_o = mem_resp_i;
  assign resp0_v_o = reset_n_i & ~empty & ~head & mem_resp_v_i;
  assign resp1_v_o = reset_n_i & ~empty & head & mem_resp_v_i;
  assign outstanding_o = cnt;
  assign error_o = err;
  always_ff @(posedge clk_i)
    if (push) ids[wptr] <= g1;
  // last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt <= '0;
      last_grant <= 1'b1;
      err <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + pw'(1);
        last_grant <= g1;
      end
      if (pop) rptr <= rptr + pw'(1);
      cnt <= cnt + cw'(push) - cw'(pop);
      if (empty & mem_resp_v_i) err <= 1'b1;
    end
endmodule

// File: tb/tb_bp_mem_port_arbiter.sv
// tb_bp_mem_port_arbiter: directed plus pseudo-random stimulus checked against a queue-based model every cycle.
module tb_bp_mem_port_arbiter;
  localparam int w = 16;
  localparam int n = 4;
  logic clk = 0, reset_n_i = 0;
  logic [w-1:0] cmd0_i = 0, cmd1_i = 0, mem_resp_i = 0;
  logic cmd0_v_i = 0, cmd1_v_i = 0, mem_cmd_ready_i = 0, mem_resp_v_i = 0;
  logic y0_en = 0, y1_en = 0;
  logic cmd0_ready_o, cmd1_ready_o, resp0_v_o, resp1_v_o, mem_cmd_v_o, mem_resp_yumi_o, error_o;
  logic resp0_yumi_i, resp1_yumi_i;
  logic [w-1:0] resp0_o, resp1_o, mem_cmd_o;
  logic [$clog2(n):0] outstanding_o;
  int tests = 0, fails = 0;
  int q[$];
  bit lg = 1, err = 0;
  always #5 clk = ~clk;
  assign resp0_yumi_i = resp0_v_o & y0_en;
  assign resp1_yumi_i = resp1_v_o & y1_en;
  bp_mem_port_arbiter #(.msg_width_p(w), .track_els_p(n)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .cmd0_i(cmd0_i), .cmd0_v_i(cmd0_v_i), .cmd0_ready_o(cmd0_ready_o),
    .cmd1_i(cmd1_i), .cmd1_v_i(cmd1_v_i), .cmd1_ready_o(cmd1_ready_o),
    .resp0_o(resp0_o), .resp0_v_o(resp0_v_o), .resp0_yumi_i(resp0_yumi_i),
    .resp1_o(resp1_o), .resp1_v_o(resp1_v_o), .resp1_yumi_i(resp1_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_check();
    bit can, who, wv, issue, r0, r1, v0, v1, y;
    if (!reset_n_i) begin
      chk("rst_ready0", cmd0_ready_o, 0);
      chk("rst_ready1", cmd1_ready_o, 0);
      chk("rst_mcv", mem_cmd_v_o, 0);
      chk("rst_v", {resp0_v_o, resp1_v_o}, 0);
      chk("rst_yumi", mem_resp_yumi_o, 0);
      chk("rst_out", outstanding_o, 0);
      chk("rst_err", error_o, 0);
      q.delete();
      lg = 1;
      err = 0;
      return;
    end
    can = mem_cmd_ready_i && q.size() < n;
    who = (cmd0_v_i && cmd1_v_i) ? !lg : cmd1_v_i;
    wv = who ? cmd1_v_i : cmd0_v_i;
    issue = wv && can;
    r0 = can && (!cmd1_v_i || !who);
    r1 = can && (!cmd0_v_i || who);
    if (q.size() == 0) begin
      v0 = 0; v1 = 0; y = mem_resp_v_i;
    end else begin
      v0 = mem_resp_v_i && q[0] == 0;
      v1 = mem_resp_v_i && q[0] == 1;
      y = q[0] == 1 ? resp1_yumi_i : resp0_yumi_i;
    end
    chk("m_ready0", cmd0_ready_o, r0);
    chk("m_ready1", cmd1_ready_o, r1);
    chk("m_mcv", mem_cmd_v_o, issue);
    if (issue) chk("m_mcmd", mem_cmd_o, who ? cmd1_i : cmd0_i);
    chk("m_resp0_v", resp0_v_o, v0);
    chk("m_resp1_v", resp1_v_o, v1);
    chk("m_resp0_d", resp0_o, mem_resp_i);
    chk("m_resp1_d", resp1_o, mem_resp_i);
    chk("m_yumi", mem_resp_yumi_o, y);
    chk("m_out", outstanding_o, q.size());
    chk("m_err", error_o, err);
    if (q.size() == 0 && mem_resp_v_i) err = 1;
    if (q.size() > 0 && y) void'(q.pop_front());
    if (issue) begin
      q.push_back(who);
      lg = who;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask
  initial begin
    cmd0_i = 16'hA0A0;
    cmd1_i = 16'hB1B1;
    mem_resp_i = 16'h5A5A;
    mem_cmd_ready_i = 1;
    tick();
    tick();
    #1;
    chk("reset_out", outstanding_o, 0);
    chk("reset_err", error_o, 0);
    reset_n_i = 1;
    cmd0_v_i = 1;
    cmd1_v_i = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant0", cmd0_ready_o, (k % 2) == 0);
      chk("rr_grant1", cmd1_ready_o, (k % 2) == 1);
      tick();
    end
    #1;
    chk("full_ready0", cmd0_ready_o, 0);
    chk("full_ready1", cmd1_ready_o, 0);
    chk("full_out", outstanding_o, 4);
    cmd1_v_i = 0;
    mem_resp_v_i = 1;
    y0_en = 1;
    #1;
    chk("fullpop_ready0", cmd0_ready_o, 0);
    chk("fullpop_yumi", mem_resp_yumi_o, 1);
    tick();
    mem_resp_v_i = 0;
    #1;
    chk("resume_out", outstanding_o, 3);
    chk("resume_ready0", cmd0_ready_o, 1);
    tick();
    cmd0_v_i = 0;
    mem_resp_v_i = 1;
    y1_en = 1;
    repeat (4) tick();
    chk("drain_out", outstanding_o, 0);
    mem_resp_v_i = 0;
    cmd0_v_i = 1;
    tick();
    cmd0_v_i = 0;
    cmd1_v_i = 1;
    tick();
    cmd1_v_i = 0;
    cmd0_v_i = 1;
    tick();
    cmd0_v_i = 0;
    #1;
    chk("seq_out", outstanding_o, 3);
    mem_resp_v_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("seq_resp0_v", resp0_v_o, k != 1);
      chk("seq_resp1_v", resp1_v_o, k == 1);
      chk("seq_out_k", outstanding_o, 3 - k);
      tick();
    end
    chk("seq_out_end", outstanding_o, 0);
    mem_resp_v_i = 0;
    cmd1_v_i = 1;
    tick();
    cmd1_v_i = 0;
    mem_resp_v_i = 1;
    y1_en = 0;
    repeat (5) begin
      #1;
      chk("stall_yumi", mem_resp_yumi_o, 0);
      chk("stall_v", resp1_v_o, 1);
      chk("stall_out", outstanding_o, 1);
      tick();
    end
    y1_en = 1;
    #1;
    chk("stall_release", mem_resp_yumi_o, 1);
    tick();
    chk("stall_out_end", outstanding_o, 0);
    #1;
    chk("err_yumi", mem_resp_yumi_o, 1);
    chk("err_no_v", {resp0_v_o, resp1_v_o}, 0);
    chk("err_pre", error_o, 0);
    tick();
    mem_resp_v_i = 0;
    #1;
    chk("err_set", error_o, 1);
    repeat (3) tick();
    chk("err_sticky", error_o, 1);
    cmd0_v_i = 1;
    tick();
    tick();
    cmd0_v_i = 0;
    #1;
    chk("arst_pre", outstanding_o, 2);
    reset_n_i = 0;
    #1;
    chk("arst_out", outstanding_o, 0);
    chk("arst_err", error_o, 0);
    chk("arst_ready", cmd0_ready_o, 0);
    tick();
    tick();
    reset_n_i = 1;
    cmd0_v_i = 1;
    cmd1_v_i = 1;
    #1;
    chk("arst_tie0", cmd0_ready_o, 1);
    chk("arst_tie1", cmd1_ready_o, 0);
    tick();
    repeat (300) begin
      cmd0_v_i = 1'($urandom);
      cmd1_v_i = 1'($urandom);
      cmd0_i = 16'($urandom);
      cmd1_i = 16'($urandom);
      mem_cmd_ready_i = ($urandom_range(0, 3) != 0);
      mem_resp_v_i = 1'($urandom);
      mem_resp_i = 16'($urandom);
      y0_en = 1'($urandom);
      y1_en = 1'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
